// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: grants one word access
// at a time, holds the strobes for LATENCY cycles and returns data/error with an ack.
module dmem_arbiter #(
  parameter int MEM_BYTES = 32,
  parameter int LATENCY   = 1,
  parameter bit PRIO_A    = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_req_i,
  input  logic        a_we_i,
  input  logic [31:0] a_addr_i,
  input  logic [31:0] a_wdata_i,
  output logic        a_ack_o,
  input  logic        b_req_i,
  input  logic        b_we_i,
  input  logic [31:0] b_addr_i,
  input  logic [31:0] b_wdata_i,
  output logic        b_ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        grant_o,
  output logic        busy_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_data_i
);
  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [31:0]   MAX_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          grant_q, grant_d;
  logic          rr_q, rr_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic          busy_q, busy_d;

  logic          pick_b;
  logic          sel_we;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          legal;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;

    // rr_q holds the last granted port; on a tie the other one wins unless A has priority
    pick_b    = b_req_i & (~a_req_i | (~PRIO_A & ~rr_q));
    sel_we    = pick_b ? b_we_i    : a_we_i;
    sel_addr  = pick_b ? b_addr_i  : a_addr_i;
    sel_wdata = pick_b ? b_wdata_i : a_wdata_i;
    legal     = (sel_addr[1:0] == 2'b00) && (sel_addr <= MAX_ADDR);

    case (state_q)
      IDLE: begin
        if (a_req_i || b_req_i) begin
          grant_d = pick_b;
          rr_d    = pick_b;
          we_d    = sel_we;
          if (legal) begin
            state_d     = BUSY;
            cnt_d       = CNT_INIT;
            err_d       = 1'b0;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            mem_read_d  = ~sel_we;
            mem_write_d = sel_we;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
            a_ack_d = ~pick_b;
            b_ack_d = pick_b;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d       = cnt_q - 1'b1;
          mem_read_d  = ~we_q;
          mem_write_d = we_q;
        end else begin
          state_d = DONE;
          rdata_d = we_q ? 32'h0 : mem_data_i;
          a_ack_d = ~grant_q;
          b_ack_d = grant_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      grant_q     <= 1'b0;
      rr_q        <= 1'b1;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign a_ack_o     = a_ack_q;
  assign b_ack_o     = b_ack_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
endmodule
